// File: rtl/pipe_adder_compensation.sv
// Two-stage, multi-lane saturating adder with a selectable rounding
// compensation term, valid/ready handshake on both sides and a
// wrapping count of delivered result vectors.
module pipe_adder_compensation #(
    parameter int unsigned DataK_width      = 4,
    parameter int unsigned truncation_width = 6,
    parameter int unsigned NUM_LANES        = 4,
    parameter int unsigned COMP_CONST       = 3,
    localparam int unsigned OW = DataK_width + truncation_width + 1,
    localparam int unsigned RW = OW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              comp_mode,
    input  logic [NUM_LANES*OW-1:0] op1_flat,
    input  logic [NUM_LANES*OW-1:0] op2_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_LANES*RW-1:0] sum_flat,
    output logic [NUM_LANES-1:0]    sat_flags,
    output logic [15:0]             xfer_count
);

    // one extra bit over the result so overflow is visible before saturation
    localparam int unsigned SW = RW + 1;

    logic                    s1_valid;
    logic [NUM_LANES*OW-1:0] s1_op1;
    logic [NUM_LANES*OW-1:0] s1_op2;
    logic [1:0]              s1_mode;

    logic                    s2_valid;
    logic [NUM_LANES*RW-1:0] s2_sum;
    logic [NUM_LANES-1:0]    s2_sat;
    logic [15:0]             xfer_q;

    logic                    s2_load;
    logic [SW-1:0]           comp_term;
    logic [SW-1:0]           lane_sum [NUM_LANES];
    logic [NUM_LANES*RW-1:0] sum_next;
    logic [NUM_LANES-1:0]    sat_next;

    // S2 frees up when empty or draining; S1 may load whenever it can move on
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    assign out_valid  = s2_valid;
    assign sum_flat   = s2_sum;
    assign sat_flags  = s2_sat;
    assign xfer_count = xfer_q;

    // compensation term selected by the mode that travelled with the vector
    always_comb begin
        comp_term = '0;
        case (s1_mode)
            2'd0:    comp_term = '0;
            2'd1:    comp_term = SW'(1);
            2'd2:    comp_term = SW'(COMP_CONST);
            default: comp_term = SW'(1) << (truncation_width - 1);
        endcase
    end

    // per-lane unsigned add with saturation to all ones on overflow
    always_comb begin
        sum_next = '0;
        sat_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum[i] = SW'(s1_op1[i*OW +: OW]) + SW'(s1_op2[i*OW +: OW]) + comp_term;
            sat_next[i] = lane_sum[i][RW];
            sum_next[i*RW +: RW] = lane_sum[i][RW] ? {RW{1'b1}} : lane_sum[i][RW-1:0];
        end
    end

    // stage 1: capture operands and mode on input transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_mode  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op1  <= op1_flat;
                s1_op2  <= op2_flat;
                s1_mode <= comp_mode;
            end
        end
    end

    // stage 2: register lane results; held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_sat   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= sum_next;
                s2_sat <= sat_next;
            end
        end
    end

    // count accepted result vectors, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_q <= '0;
        end else if (s2_valid && out_ready) begin
            xfer_q <= xfer_q + 16'd1;
        end
    end

endmodule
